// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: producer requests, grants, freeze and
// the registered register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               freeze;
  logic               write_enable;
  logic [AW-1:0]      write_addr;
  logic [DW-1:0]      write_data;
  logic               busy;

  modport master (
    output req_valid, req_addr, req_data, freeze,
    input  req_ready, busy,
    input  write_enable, write_addr, write_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, freeze,
    output req_ready, busy,
    output write_enable, write_addr, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port.
// WB_ARB_COLLISION_CHK_EN adds a sticky same-address collision flag.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic clk,
  input  logic reset_n,
`ifdef WB_ARB_COLLISION_CHK_EN
  output logic collision_err,
`endif
  regfile_wb_arbiter_if.slave wb
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  logic [LW-1:0]   last_q, last_d;
  logic [LW-1:0]   win;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  int              idx;

  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;

  // Rotating search starting just after the last winner.
  always_comb begin
    gnt = '0;
    win = last_q;
    idx = 0;
    if (reset_n && !wb.freeze) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(last_q) + k) % NREQ;
        if (gnt == '0 && wb.req_valid[idx]) begin
          gnt[idx] = 1'b1;
          win      = LW'(idx);
        end
      end
    end
  end

  assign xfer = |gnt;

  always_comb begin
    last_d = last_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (xfer) begin
      last_d = win;
      addr_d = wb.req_addr[int'(win)*AW +: AW];
      data_d = wb.req_data[int'(win)*DW +: DW];
      we_d   = |addr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= LAST_RST;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign wb.req_ready    = gnt;
  assign wb.busy         = (|wb.req_valid) && !xfer;
  assign wb.write_enable = we_q;
  assign wb.write_addr   = addr_q;
  assign wb.write_data   = data_q;

`ifdef WB_ARB_COLLISION_CHK_EN
  logic col_q, col_d, hit;

  // Any two live requests aimed at the same nonzero register.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (wb.req_valid[i] && wb.req_valid[j] &&
            wb.req_addr[i*AW +: AW] == wb.req_addr[j*AW +: AW] &&
            |wb.req_addr[i*AW +: AW])
          hit = 1'b1;
      end
    end
    col_d = col_q | hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) col_q <= 1'b0;
    else          col_q <= col_d;
  end

  assign collision_err = col_q;
`endif

endmodule
